// File: rtl/pcie_rq_arbiter_pkg.sv
// Shared types and default geometry for the PCIe RQ requester arbiter.
// Holds the arbiter state encoding and the round-robin pointer helper.
package pcie_rq_arb_pkg;

   typedef enum logic {ARB, PKT} arb_state_t;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_DATA_W  = 64;
   localparam int unsigned DEF_KEEP_W  = DEF_DATA_W / 32;
   localparam int unsigned DEF_USER_W  = 85;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/pcie_rq_arbiter_if.sv
// Requester-side and PCIe-core-side AXI-Stream bundle of the RQ arbiter.
// slave = arbiter view, master = environment (DMA engines + PCIe core) view.
interface pcie_rq_arbiter_if
   import pcie_rq_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned KEEP_W  = DATA_W / 32,
   parameter int unsigned USER_W  = DEF_USER_W
) ();

   logic [NUM_REQ*DATA_W-1:0] req_tdata;
   logic [NUM_REQ*USER_W-1:0] req_tuser;
   logic [NUM_REQ*KEEP_W-1:0] req_tkeep;
   logic [NUM_REQ-1:0]        req_tlast;
   logic [NUM_REQ-1:0]        req_tvalid;
   logic [NUM_REQ-1:0]        req_tready;

   logic [DATA_W-1:0]         s_axis_rq_tdata;
   logic [USER_W-1:0]         s_axis_rq_tuser;
   logic [KEEP_W-1:0]         s_axis_rq_tkeep;
   logic                      s_axis_rq_tlast;
   logic                      s_axis_rq_tvalid;
   logic                      s_axis_rq_tready;

   modport slave (
      input  req_tdata, req_tuser, req_tkeep, req_tlast, req_tvalid,
      output req_tready,
      output s_axis_rq_tdata, s_axis_rq_tuser, s_axis_rq_tkeep,
      output s_axis_rq_tlast, s_axis_rq_tvalid,
      input  s_axis_rq_tready
   );

   modport master (
      output req_tdata, req_tuser, req_tkeep, req_tlast, req_tvalid,
      input  req_tready,
      input  s_axis_rq_tdata, s_axis_rq_tuser, s_axis_rq_tkeep,
      input  s_axis_rq_tlast, s_axis_rq_tvalid,
      output s_axis_rq_tready
   );

endinterface

// File: rtl/pcie_rq_arbiter_skid.sv
// Two-entry AXI-Stream register slice: registered output, full throughput,
// input ready derived from occupancy only so downstream ready never leaks upstream.
module pcie_axis_skid #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic [1:0]   count_q, count_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] spare_q, spare_d;
   logic         push, pop;

   assign in_ready_o  = (count_q != 2'd2);
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = head_q;
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   // head is always the presented beat; spare only holds the beat that arrived during a stall
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      spare_d = spare_q;
      case (count_q)
         2'd0: begin
            if (push) begin
               head_d  = in_data_i;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = in_data_i;
            end else if (push) begin
               spare_d = in_data_i;
               count_d = 2'd2;
            end else if (pop) begin
               count_d = 2'd0;
            end
         end
         2'd2: begin
            if (pop) begin
               head_d  = spare_q;
               count_d = 2'd1;
            end
         end
         default: count_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         head_q  <= '0;
         spare_q <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         spare_q <= spare_d;
      end
   end

endmodule

// File: rtl/pcie_rq_arbiter.sv
// Packet-granular round-robin arbiter sharing the PCIe RQ AXI-Stream port
// among NUM_REQ requesters, followed by a 2-entry registered output slice.
module pcie_rq_arbiter
   import pcie_rq_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned KEEP_W  = DATA_W / 32,
   parameter int unsigned USER_W  = DEF_USER_W
) (
   input  logic               pcie_clk_in,
   input  logic               pcie_reset_n,
   input  logic               pcie_link_up,
   pcie_rq_arbiter_if.slave   rq,
   output logic [NUM_REQ-1:0] arb_grant
);

   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned SKID_W = USER_W + KEEP_W + 1 + DATA_W;

   arb_state_t         state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   gidx_q;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] tready_w;
   logic               skid_in_ready;
   logic               beat_fire;
   logic               last_fire;
   logic [DATA_W-1:0]  sel_data;
   logic [USER_W-1:0]  sel_user;
   logic [KEEP_W-1:0]  sel_keep;
   logic               sel_last;
   logic [SKID_W-1:0]  skid_out;

   // first valid requester at or after rr_ptr, wrapping
   always_comb begin
      int unsigned cand;
      cand       = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (32'(rr_ptr_q) + k) % NUM_REQ;
         if (!pick_found && rq.req_tvalid[IDX_W'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      sel_data = '0;
      sel_user = '0;
      sel_keep = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            sel_data = sel_data | rq.req_tdata[i*DATA_W +: DATA_W];
            sel_user = sel_user | rq.req_tuser[i*USER_W +: USER_W];
            sel_keep = sel_keep | rq.req_tkeep[i*KEEP_W +: KEEP_W];
            sel_last = sel_last | rq.req_tlast[i];
         end
      end
   end

   // grant_q is non-zero only in PKT, so it alone gates requester ready
   assign tready_w      = grant_q & {NUM_REQ{skid_in_ready}};
   assign rq.req_tready = tready_w;
   assign beat_fire     = |(rq.req_tvalid & tready_w);
   assign last_fire     = |(rq.req_tvalid & tready_w & rq.req_tlast);
   assign arb_grant     = grant_q;

   always_ff @(posedge pcie_clk_in or negedge pcie_reset_n) begin
      if (!pcie_reset_n) begin
         state_q  <= ARB;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         gidx_q   <= '0;
      end else begin
         case (state_q)
            ARB: begin
               if (pcie_link_up && pick_found) begin
                  grant_q <= NUM_REQ'(1) << pick_idx;
                  gidx_q  <= pick_idx;
                  state_q <= PKT;
               end
            end
            PKT: begin
               if (last_fire) begin
                  rr_ptr_q <= IDX_W'(rr_next(32'(gidx_q), NUM_REQ));
                  grant_q  <= '0;
                  state_q  <= ARB;
               end
            end
            default: state_q <= ARB;
         endcase
      end
   end

   pcie_axis_skid #(
      .W (SKID_W)
   ) u_skid (
      .clk_i       (pcie_clk_in),
      .rst_ni      (pcie_reset_n),
      .in_valid_i  (beat_fire),
      .in_ready_o  (skid_in_ready),
      .in_data_i   ({sel_user, sel_keep, sel_last, sel_data}),
      .out_valid_o (rq.s_axis_rq_tvalid),
      .out_ready_i (rq.s_axis_rq_tready),
      .out_data_o  (skid_out)
   );

   assign {rq.s_axis_rq_tuser, rq.s_axis_rq_tkeep, rq.s_axis_rq_tlast, rq.s_axis_rq_tdata} = skid_out;

endmodule
